// File: rtl/mem_port_master.sv
// Load/store initiator for the 32x64k single-port data memory with a credit-limited response FIFO.
// Optional macro MEM_ADDR_CHECK_EN: compare returned Ao against the issued load address (sticky err).
module mem_port_master #(
  parameter int unsigned WORD      = 32,
  parameter int unsigned ADDR      = 16,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [ADDR-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_data,
  output logic [ADDR-1:0] rsp_addr,
  output logic [ADDR-1:0] mem_a,
  output logic            mem_w,
  output logic [WORD-1:0] mem_d,
  input  logic [WORD-1:0] mem_q,
  input  logic [ADDR-1:0] mem_ao,
  output logic            err
);

  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  logic            inflight_q, inflight_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d, occ;
  logic [WORD-1:0] data_q [RSP_DEPTH];
  logic [ADDR-1:0] addr_q [RSP_DEPTH];
  logic            fire, push, pop;
  logic [ADDR-1:0] push_addr;

  always_comb begin
    // Credit counts the load still in the memory pipe, so the FIFO can never overflow.
    occ        = count_q + CW'(inflight_q);
    req_ready  = (occ < DEPTH_C) & ~rst;
    fire       = req_valid & req_ready;
    mem_a      = req_addr;
    mem_d      = req_wdata;
    mem_w      = fire & req_we;
    inflight_d = fire & ~req_we;
    push       = inflight_q;
    rsp_valid  = (count_q != '0);
    pop        = rsp_valid & rsp_ready;
    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + PW'(1) : rptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rsp_data   = data_q[rptr_q];
    rsp_addr   = addr_q[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      if (push) begin
        data_q[wptr_q] <= mem_q;
        addr_q[wptr_q] <= push_addr;
      end
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  logic [ADDR-1:0] exp_addr_q;
  logic            err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (inflight_d) exp_addr_q <= req_addr;
      if (push && (mem_ao != exp_addr_q)) err_q <= 1'b1;
    end
  end

  always_comb begin
    push_addr = exp_addr_q;
    err       = err_q;
  end
`else
  always_comb begin
    push_addr = mem_ao;
    err       = 1'b0;
  end
`endif

endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Initiator for the 32x64k single-port data memory: accepts load/store requests from the core over a valid/ready handshake and drives the memory's A/W/D pins.
- Tracks the memory's fixed 1-cycle registered read latency and captures Q/Ao.
- Returns read data to the core through a small response FIFO with backpressure.
- Sits between the core's load/store unit and the memory macro.

Parameters:
WORD, 32, data width (matches `WORD)
ADDR, 16, address width (matches `ADDR)
RSP_DEPTH, 4, response FIFO entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=store, 0=load
req_addr  in  ADDR  request address
req_wdata  in  WORD  store data
rsp_valid  out  1  load response valid
rsp_ready  in  1  core accepts response
rsp_data  out  WORD  load data
rsp_addr  out  ADDR  load address
mem_a  out  ADDR  to memory A
mem_w  out  1  to memory W
mem_d  out  WORD  to memory D
mem_q  in  WORD  from memory Q
mem_ao  in  ADDR  from memory Ao
err  out  1  sticky address-check error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Fire: fire = req_valid & req_ready.
- Memory drive (combinational from the request):
  - mem_a = req_addr.
  - mem_d = req_wdata.
  - mem_w = fire & req_we.
  - When idle, mem_w=0. The memory performs a harmless read of req_addr; its result is ignored.
- Occupancy: occ = inflight + fifo_count, from registered state only.
  - req_ready = (occ < RSP_DEPTH) & ~rst_q, where rst_q is 1 in the reset cycle.
  - No combinational path from rsp_ready to req_ready.
- Stores:
  - Consume no credit and produce no response.
  - Memory executes in order, so a load issued the cycle after a store to the same address returns the new data.
- Load issued in cycle N:
  - Set inflight and record the address in exp_addr.
  - Cycle N+1: mem_q/mem_ao are valid. Push {mem_q, mem_ao} into the FIFO at end of N+1.
  - Cycle N+2: rsp_valid=1. Load-to-response latency is 2 cycles.
- Back-to-back loads: one new load per cycle is sustained while the FIFO drains (rsp_ready=1). Steady occ <= 2.
- mem_q is ignored whenever no load was issued the previous cycle. The memory holds Q during writes/idle; this must never create a response.
- Response FIFO:
  - rsp_valid = fifo_count != 0. rsp_data/rsp_addr come from the head entry.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - Overflow is impossible by credit rule. Pop while empty is a no-op.
  - Pointers wrap modulo RSP_DEPTH.
- Reset values: req_ready=0 in the reset cycle, then 1; rsp_valid=0; rsp_data=0; rsp_addr=0; err=0.
  - FIFO count, pointers and inflight are cleared.
- Reset mid-operation:
  - An in-flight load is dropped; its mem_q arriving the next cycle is discarded.
  - Buffered responses are lost.
  - Memory contents are untouched.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined: when an in-flight load's data is pushed, compare mem_ao with exp_addr. On mismatch, set err=1, sticky until rst. The response is still pushed using exp_addr as rsp_addr.
- Undefined:
  - err is tied 0.
  - mem_ao is unused.
  - rsp_addr comes from mem_ao.

Test Plan:
- Preload mem[0x0010]=0xDEADBEEF; load 0x0010 at cycle 5 with rsp_ready=1 -> rsp_valid at cycle 7 with rsp_data=0xDEADBEEF, rsp_addr=0x0010, for exactly one cycle.
- Store 0x12345678 to 0x0020 at cycle N, load 0x0020 at N+1 -> response at N+3 with data 0x12345678. No response is produced for the store.
- Eight consecutive loads 0x0000..0x0007, rsp_ready=1 -> req_ready stays 1. Eight responses on consecutive cycles, in order, with matching addresses.
- rsp_ready=0, loads streamed -> req_ready drops after the 4th accepted load. Raising rsp_ready -> 4 responses drain in order, then req_ready returns to 1.
- Assert rst the cycle after a load issues -> no rsp_valid afterwards. req_ready=0 during reset, 1 the cycle after. A subsequent load works normally.
- With MEM_ADDR_CHECK_EN, force mem_ao=0xFFFF on a load to 0x0004 -> err=1, held until rst; rsp_addr=0x0004. Without the macro, err stays 0.
